// File: rtl/rsa_keygen_pkg.sv
// Shared definitions for the RSA key generator: FSM encodings and timing constants.
package rsa_keygen_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MUL    = 3'd1;
    localparam logic [2:0] ST_GSTART = 3'd2;
    localparam logic [2:0] ST_GWAIT  = 3'd3;
    localparam logic [2:0] ST_FIX    = 3'd4;

    localparam int unsigned LAT_PER_BIT       = 9;
    localparam int unsigned LAT_FIXED         = 3;
    localparam int unsigned GCD_STEPS_PER_BIT = 8;

    // Start-sampling edge to the edge that raises finish.
    function automatic int unsigned keygen_latency(input int unsigned width);
        return LAT_PER_BIT * width + LAT_FIXED;
    endfunction

    // Fixed step budget of the binary extended GCD; covers its worst case on 2*width-bit operands.
    function automatic int unsigned gcd_steps(input int unsigned width);
        return GCD_STEPS_PER_BIT * width;
    endfunction

endpackage

// File: rtl/rsa_keygen_gcd.sv
// Fixed-latency binary extended GCD: gcd = C*a + t*b, one reduction step per cycle.
module gcd
    import rsa_keygen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0]   gcd,
    output logic [2*WIDTH-1:0]   t,
    output logic                 finish
);

    localparam int          N     = 2 * WIDTH;
    localparam int          CW    = N + 2;
    localparam int          KBW   = $clog2(N + 1);
    localparam int unsigned STEPS = gcd_steps(WIDTH);
    localparam int          SW    = $clog2(STEPS + 1);

    logic [N-1:0]          x, y, u, v;
    logic [N-1:0]          x_nx, y_nx, u_nx, v_nx;
    logic signed [CW-1:0]  ca, cb, cc, cd;
    logic signed [CW-1:0]  ca_nx, cb_nx, cc_nx, cd_nx;
    logic signed [CW-1:0]  x_s, y_s;
    logic [KBW-1:0]        k, k_nx;
    logic [SW-1:0]         cnt;
    logic                  running;

    assign x_s = {2'b00, x};
    assign y_s = {2'b00, y};

    // Invariants: u = ca*x + cb*y, v = cc*x + cd*y; once u reaches 0 every step is a hold.
    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        x_nx  = x;  y_nx  = y;  u_nx  = u;  v_nx  = v;
        ca_nx = ca; cb_nx = cb; cc_nx = cc; cd_nx = cd;
        k_nx  = k;
        if (u == '0) begin
            u_nx = u;
        end else if (!u[0] && !v[0]) begin
            x_nx = x >> 1;
            y_nx = y >> 1;
            u_nx = u >> 1;
            v_nx = v >> 1;
            k_nx = k + KBW'(1);
        end else if (!u[0]) begin
            u_nx = u >> 1;
            if (!ca[0] && !cb[0]) begin
                ca_nx = ca >>> 1;
                cb_nx = cb >>> 1;
            end else begin
                ca_nx = (ca + y_s) >>> 1;
                cb_nx = (cb - x_s) >>> 1;
            end
        end else if (!v[0]) begin
            v_nx = v >> 1;
            if (!cc[0] && !cd[0]) begin
                cc_nx = cc >>> 1;
                cd_nx = cd >>> 1;
            end else begin
                cc_nx = (cc + y_s) >>> 1;
                cd_nx = (cd - x_s) >>> 1;
            end
        end else if (u >= v) begin
            u_nx  = u - v;
            ca_nx = ca - cc;
            cb_nx = cb - cd;
        end else begin
            v_nx  = v - u;
            cc_nx = cc - ca;
            cd_nx = cd - cb;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0; y <= '0; u <= '0; v <= '0;
            ca <= '0; cb <= '0; cc <= '0; cd <= '0;
            k <= '0; cnt <= '0; running <= 1'b0;
        end else if (start) begin
            x <= a; y <= b; u <= a; v <= b;
            ca <= CW'(1); cb <= '0; cc <= '0; cd <= CW'(1);
            k <= '0; cnt <= '0; running <= 1'b1;
        end else if (running) begin
            if (cnt == SW'(STEPS)) begin
                running <= 1'b0;
            end else begin
                x <= x_nx; y <= y_nx; u <= u_nx; v <= v_nx;
                ca <= ca_nx; cb <= cb_nx; cc <= cc_nx; cd <= cd_nx;
                k <= k_nx;
                cnt <= cnt + SW'(1);
            end
        end
    end

    assign gcd    = v << k;
    assign t      = cd[N-1:0];
    assign finish = running && (cnt == SW'(STEPS));

endmodule

// File: rtl/rsa_keygen.sv
// RSA key generator: n = p*q, d = e^-1 mod (p-1)(q-1), with fixed data-independent latency.
module rsa_keygen
    import rsa_keygen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     p,
    input  logic [WIDTH-1:0]     q,
    input  logic [2*WIDTH-1:0]   e,
    output logic [2*WIDTH-1:0]   n,
    output logic [2*WIDTH-1:0]   d,
    output logic                 valid,
    output logic                 busy,
    output logic                 finish
);

    localparam int KW  = 2 * WIDTH;
    localparam int BCW = $clog2(WIDTH + 1);

    logic [2:0]        state;
    logic [BCW-1:0]    bit_cnt;
    logic [KW-1:0]     mc_n, mc_phi, n_acc, phi_acc, e_reg;
    logic [WIDTH-1:0]  mp_n, mp_phi;
    logic [KW-1:0]     g_res, t_reg;
    logic [WIDTH-1:0]  p_m1, q_m1;
    logic              e_ok, key_ok;
    logic [KW-1:0]     gcd_b, gcd_g, gcd_t, t_plus, d_fix;
    logic              gcd_start, gcd_finish;

    assign p_m1 = p - WIDTH'(1);
    assign q_m1 = q - WIDTH'(1);

    // Out-of-range e is replaced by 1 so the GCD always runs on a nonzero operand.
    assign e_ok      = (e_reg != '0) && (e_reg < phi_acc);
    assign gcd_b     = e_ok ? e_reg : KW'(1);
    assign gcd_start = (state == ST_GSTART);

    gcd #(.WIDTH(WIDTH)) u_gcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (gcd_start),
        .a      (phi_acc),
        .b      (gcd_b),
        .gcd    (gcd_g),
        .t      (gcd_t),
        .finish (gcd_finish)
    );

    // Both candidates are always formed; t is read as two's complement.
    assign t_plus = t_reg + phi_acc;
    assign d_fix  = t_reg[KW-1] ? t_plus : t_reg;
    assign key_ok = e_ok && (g_res == KW'(1));
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            mc_n    <= '0; mc_phi <= '0;
            mp_n    <= '0; mp_phi <= '0;
            n_acc   <= '0; phi_acc <= '0; e_reg <= '0;
            g_res   <= '0; t_reg  <= '0;
            n       <= '0; d      <= '0;
            valid   <= 1'b0;
            finish  <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mc_n    <= {{WIDTH{1'b0}}, p};
                        mc_phi  <= {{WIDTH{1'b0}}, p_m1};
                        mp_n    <= q;
                        mp_phi  <= q_m1;
                        e_reg   <= e;
                        n_acc   <= '0;
                        phi_acc <= '0;
                        bit_cnt <= '0;
                        state   <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    // Masked add every cycle keeps timing and activity operand-independent.
                    n_acc   <= n_acc   + (mc_n   & {KW{mp_n[0]}});
                    phi_acc <= phi_acc + (mc_phi & {KW{mp_phi[0]}});
                    mc_n    <= mc_n   << 1;
                    mc_phi  <= mc_phi << 1;
                    mp_n    <= mp_n   >> 1;
                    mp_phi  <= mp_phi >> 1;
                    bit_cnt <= bit_cnt + BCW'(1);
                    if (bit_cnt == BCW'(WIDTH - 1))
                        state <= ST_GSTART;
                end
                ST_GSTART: state <= ST_GWAIT;
                ST_GWAIT: begin
                    if (gcd_finish) begin
                        g_res <= gcd_g;
                        t_reg <= gcd_t;
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    n      <= n_acc;
                    d      <= key_ok ? d_fix : '0;
                    valid  <= key_ok;
                    finish <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_keygen.sv
// Directed testbench for rsa_keygen at WIDTH=8 with hand-computed RSA vectors.
module tb_rsa_keygen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  p, q;
    logic [15:0] e, n, d;
    logic        valid, busy, finish;

    int checks = 0;
    int errors = 0;

    rsa_keygen #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .p      (p),
        .q      (q),
        .e      (e),
        .n      (n),
        .d      (d),
        .valid  (valid),
        .busy   (busy),
        .finish (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; returns 1 ns after the sampling edge.
    task automatic launch(input logic [7:0] pp, input logic [7:0] qq, input logic [15:0] ee);
        p = pp; q = qq; e = ee; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges until finish is seen, bounded at 200.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (finish) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; p = '0; q = '0; e = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (n !== 16'd0)    begin errors++; $display("FAIL reset_n got %0d want 0", n); end
        checks++; if (d !== 16'd0)    begin errors++; $display("FAIL reset_d got %0d want 0", d); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", finish); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int cyc;
        launch(8'd61, 8'd53, 16'd17);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_done(cyc);
        checks++; if (cyc != 75)        begin errors++; $display("FAIL basic_latency got %0d want 75", cyc); end
        checks++; if (n !== 16'd3233)   begin errors++; $display("FAIL basic_n got %0d want 3233", n); end
        checks++; if (d !== 16'd2753)   begin errors++; $display("FAIL basic_d got %0d want 2753", d); end
        checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL basic_valid got %b want 1", valid); end
        @(posedge clk);
        #1;
        checks++; if (finish !== 1'b0)  begin errors++; $display("FAIL basic_pulse got %b want 0", finish); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL basic_idle got %b want 0", busy); end
        checks++; if (d !== 16'd2753)   begin errors++; $display("FAIL basic_hold got %0d want 2753", d); end
    endtask

    task automatic test_gcd_fail;
        int cyc;
        launch(8'd61, 8'd53, 16'd3);
        wait_done(cyc);
        checks++; if (cyc != 75)       begin errors++; $display("FAIL gcd3_latency got %0d want 75", cyc); end
        checks++; if (n !== 16'd3233)  begin errors++; $display("FAIL gcd3_n got %0d want 3233", n); end
        checks++; if (d !== 16'd0)     begin errors++; $display("FAIL gcd3_d got %0d want 0", d); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL gcd3_valid got %b want 0", valid); end
    endtask

    task automatic test_e_range;
        int cyc;
        logic [15:0] ev [2] = '{16'd0, 16'd3120};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            launch(8'd61, 8'd53, ev[i]);
            wait_done(cyc);
            checks++; if (cyc != 75)      begin errors++; $display("FAIL erange_latency e=%0d got %0d want 75", ev[i], cyc); end
            checks++; if (d !== 16'd0)    begin errors++; $display("FAIL erange_d e=%0d got %0d want 0", ev[i], d); end
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL erange_valid e=%0d got %b want 0", ev[i], valid); end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        launch(8'd11, 8'd13, 16'd7);
        wait_done(cyc);
        checks++; if (cyc != 75)      begin errors++; $display("FAIL b2b1_latency got %0d want 75", cyc); end
        checks++; if (n !== 16'd143)  begin errors++; $display("FAIL b2b1_n got %0d want 143", n); end
        checks++; if (d !== 16'd103)  begin errors++; $display("FAIL b2b1_d got %0d want 103", d); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b1_valid got %b want 1", valid); end
        launch(8'd5, 8'd11, 16'd13);
        wait_done(cyc);
        checks++; if (cyc != 75)      begin errors++; $display("FAIL b2b2_latency got %0d want 75", cyc); end
        checks++; if (n !== 16'd55)   begin errors++; $display("FAIL b2b2_n got %0d want 55", n); end
        checks++; if (d !== 16'd37)   begin errors++; $display("FAIL b2b2_d got %0d want 37", d); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b2_valid got %b want 1", valid); end
    endtask

    task automatic test_reset_abort;
        int cyc;
        logic seen;
        @(posedge clk);
        #1;
        launch(8'd11, 8'd13, 16'd7);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (n !== 16'd0)     begin errors++; $display("FAIL abort_n got %0d want 0", n); end
        checks++; if (d !== 16'd0)     begin errors++; $display("FAIL abort_d got %0d want 0", d); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL abort_valid got %b want 0", valid); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (finish) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0)   begin errors++; $display("FAIL abort_no_finish got %b want 0", seen); end
        launch(8'd61, 8'd53, 16'd17);
        wait_done(cyc);
        checks++; if (cyc != 75)       begin errors++; $display("FAIL abort_restart_latency got %0d want 75", cyc); end
        checks++; if (d !== 16'd2753)  begin errors++; $display("FAIL abort_restart_d got %0d want 2753", d); end
        checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL abort_restart_valid got %b want 1", valid); end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        @(posedge clk);
        #1;
        launch(8'd11, 8'd13, 16'd7);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (finish) break;
            if (cyc == 10 || cyc == 60) begin
                p = 8'd61; q = 8'd53; e = 16'd17; start = 1'b1;
            end
        end
        start = 1'b0;
        checks++; if (cyc != 75)      begin errors++; $display("FAIL busy_start_latency got %0d want 75", cyc); end
        checks++; if (n !== 16'd143)  begin errors++; $display("FAIL busy_start_n got %0d want 143", n); end
        checks++; if (d !== 16'd103)  begin errors++; $display("FAIL busy_start_d got %0d want 103", d); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL busy_start_valid got %b want 1", valid); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gcd_fail();
        test_e_range();
        test_back_to_back();
        test_reset_abort();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_keygen.md
RSA_KEYGEN -- requirements
Module: rsa_keygen

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, prime width in bits; key/modulus width is 2*WIDTH.
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request, sampled only in IDLE.
- p  input  WIDTH  prime p, unsigned.
- q  input  WIDTH  prime q, unsigned.
- e  input  2*WIDTH  public exponent, unsigned.
- n  output  2*WIDTH  modulus p*q.
- d  output  2*WIDTH  private exponent, e^-1 mod phi.
- valid  output  1  key valid: gcd(phi,e)==1 and 0<e<phi.
- busy  output  1  high whenever state != IDLE.
- finish  output  1  one-cycle pulse when n/d/valid are updated.

Function
REQ-003 SHALL implement FSM IDLE -> MUL -> GSTART -> GWAIT -> FIX -> IDLE; no other states.
REQ-004 SHALL, in IDLE on start=1, register p, q and e, clear both product accumulators and the bit counter, and go to MUL; start in any other state is ignored.
REQ-005 SHALL, in MUL, compute n=p*q and phi=(p-1)*(q-1) with two parallel LSB-first shift-add multipliers, one multiplier bit per cycle, exactly WIDTH cycles, then go to GSTART.
REQ-006 SHALL compute p-1 and q-1 modulo 2^WIDTH (p=0 wraps) and all products modulo 2^(2*WIDTH).
REQ-007 SHALL, in each MUL cycle, add an operand masked by the current multiplier bit (AND-mask, never a data-dependent branch or skip), so MUL timing and activity pattern are independent of operand values.
REQ-008 SHALL, in GSTART, drive gcd start for exactly one cycle with a=phi and b=e when 0<e<phi, else a=phi and b=1 (substitution keeps the GCD run time data-independent); then go to GWAIT.
REQ-009 SHALL, in GWAIT, hold a/b stable and wait for gcd finish; on finish, capture the gcd result and t, and go to FIX.
REQ-010 SHALL, in FIX, treat t as 2*WIDTH-bit two's complement: d = t+phi (mod 2^(2*WIDTH)) if t[2*WIDTH-1]=1, else d=t. Both the add and the select SHALL be computed unconditionally.
REQ-011 SHALL, in FIX, set valid=1 only if the gcd result==1 and the e range check of REQ-008 passed; else set valid=0 and d=0.
REQ-012 SHALL, in FIX, register n, d and valid, pulse finish=1 for one cycle, and go to IDLE.
REQ-013 SHALL hold n, d and valid stable from the finish pulse until the next FIX; they are not cleared on start.
REQ-014 SHALL fix latency at 9*WIDTH+3 cycles from the start-sampling edge to the edge that raises finish, for all input values, including invalid keys (75 cycles at WIDTH=8).
REQ-015 SHALL accept a new start in the cycle after finish (back-to-back operation).

Reset
REQ-016 SHALL, on rst_n=0 at any time, including mid-operation, immediately force state=IDLE and n=0, d=0, valid=0, busy=0, finish=0, and clear all internal registers; the gcd instance shares rst_n.
REQ-017 SHALL produce no finish pulse for an operation aborted by reset; the first start after rst_n rises is accepted normally.

Structure
REQ-018 SHALL place the state encodings and the latency constant (9*WIDTH+3) in the shared RSA package; WIDTH stays a module parameter.
REQ-019 SHALL instantiate exactly one sub-module, gcd, with parameter WIDTH, consuming its gcd, t and finish outputs; the multipliers are inline.

Verification
REQ-020 SHALL cover WIDTH=8, p=61, q=53, e=17 -> n=3233, d=2753, valid=1, finish exactly 75 cycles after start.
REQ-021 SHALL cover p=61, q=53, e=3 (gcd=3) -> n=3233, valid=0, d=0, latency 75.
REQ-022 SHALL cover e=0 and e=3120 (>=phi) with p=61, q=53 -> valid=0, d=0, latency 75, no hang.
REQ-023 SHALL cover p=11, q=13, e=7 followed immediately by p=5, q=11, e=13 -> n=143, d=103, valid=1; then n=55, d=37, valid=1; each latency 75.
REQ-024 SHALL cover rst_n asserted 30 cycles after start -> outputs 0 at once, no finish pulse; a new start with p=61, q=53, e=17 then gives d=2753.
REQ-025 SHALL cover start pulsed while busy -> request ignored, result and latency of the original operation unchanged.
